vga_fb_arbiter: RTL and testbench
=================================

// Module: vga_fb_arbiter
// PURPOSE
// - Shares one single-port synchronous frame-buffer RAM between the VGA pixel fetch and one pixel writer.
// - The VGA fetch is the hard-deadline client: one request every 4 clk.
// - The writer (e.g. IR sprite/position updater) uses a valid/ready handshake and is served in the idle slots.
// - Sits between the VGA signal generator (req/en/col/row) and the colour output stage.
// PARAMETERS
// - FB_W   160  frame-buffer width in pixels.
// - FB_H   120  frame-buffer height in pixels.
// - SCALE  2    log2 upscale; screen x,y >> SCALE give buffer x,y.
// - H_OFF  49   generator col value of first visible pixel.
// - V_OFF  33   generator row value of first visible line.
// - AW     15   RAM address width; must satisfy 2^AW >= FB_W*FB_H.
// - DW     8    pixel width.
// PORTS
// - clk        in   1   system clock; all logic on posedge.
// - rst_n      in   1   asynchronous active-low reset.
// - vga_req    in   1   one-cycle pixel fetch strobe.
// - vga_en     in   1   visible-area flag, sampled with vga_req.
// - vga_col    in   10  generator column, sampled with vga_req.
// - vga_row    in   10  generator row, sampled with vga_req.
// - pix_data   out  DW  pixel to colour stage; registered.
// - pix_valid  out  1   one-cycle pulse: pix_data updated.
// - wr_valid   in   1   writer has a pixel.
// - wr_ready   out  1   one-cycle pulse: write accepted.
// - wr_addr    in   AW  buffer address, y*FB_W+x.
// - wr_data    in   DW  pixel value.
// - mem_addr   out  AW(+1)  RAM address (+1 MSB with FB_DOUBLE_BUFFER_EN).
// - mem_we     out  1   RAM write enable.
// - mem_wdata  out  DW  RAM write data.
// - mem_rdata  in   DW  RAM read data; valid 1 clk after address.
// BEHAVIOUR
// - Reset: state IDLE, pend=0; all outputs 0, including pix_data, pix_valid, wr_ready, mem_*.
// - FSM IDLE -> RD -> CAP -> IDLE, and IDLE -> WR -> IDLE.
// - IDLE, priority order:
//   - (vga_req|pend) -> RD.
//   - else wr_valid -> WR.
//   - else stay IDLE.
// - Request latch: vga_req/vga_en/col/row are captured whenever vga_req=1.
//   - If vga_req arrives outside IDLE, it sets pend; pend clears on entry to RD.
//   - A second vga_req while pend=1 overwrites the captured values; no error.
// - Address: a = ((row-V_OFF)>>SCALE)*FB_W + ((col-H_OFF)>>SCALE), using 10-bit unsigned subtraction.
// - RD: if the captured en=1, drive mem_addr=a, mem_we=0. If en=0, or a >= FB_W*FB_H, do not access the RAM (mem_addr holds).
// - CAP: pix_data <= (access made) ? mem_rdata : 0 (black); pix_valid=1 for 1 clk.
// - Latency: vga_req at cycle T (IDLE) -> pix_valid at T+3. Worst case (WR in flight) -> T+4. Both are within the 4-clk budget.
// - WR: mem_addr=wr_addr, mem_wdata=wr_data, mem_we=1 for exactly 1 clk; wr_ready=1 in the same cycle.
//   - wr_addr >= FB_W*FB_H: wr_ready still pulses, mem_we stays 0 (write dropped).
// - Writer must hold wr_valid/addr/data stable until wr_ready. Back-to-back writes are allowed: at most one write per 2 clk.
// - mem_we=0 in every state except WR.
// - rst_n asserted mid-operation: immediate return to reset values; a pending fetch or write is lost (writer retries).
// CONFIGURATION
// - FB_DOUBLE_BUFFER_EN defined:
//   - Adds ports swap_req (in, 1) and swap_done (out, 1-clk pulse). mem_addr is AW+1 bits.
//   - Writes go to bank wr_bank; reads go to ~wr_bank.
//   - swap_req (level or pulse) sets swap_pend.
//   - The swap is applied at the captured fetch with col==H_OFF && row==V_OFF (first visible pixel): wr_bank toggles before that RD, swap_done pulses, swap_pend clears.
//   - Reset: wr_bank=0, swap_pend=0, swap_done=0.
// - FB_DOUBLE_BUFFER_EN undefined: single bank; mem_addr is AW bits; swap ports absent.
// TESTING
// - Reset release, no traffic -> all outputs 0, no mem_we for 100 clk.
// - vga_req with en=1, col=49, row=33; RAM[0]=0x5A -> mem_addr=0 at T+1, pix_data=0x5A with pix_valid at T+3.
// - vga_req with en=1, col=53, row=37 -> mem_addr=161; en=0 -> no RAM read, pix_data=0x00 at T+3.
// - wr_valid, wr_addr=200, wr_data=0x3C one clk before vga_req -> mem_we at T, fetch pix_valid at T+4, RAM[200]=0x3C.
// - wr_addr=19200 -> wr_ready pulses, mem_we never 1.
// - With FB_DOUBLE_BUFFER_EN: swap_req mid-frame -> swap_done at next first-pixel fetch, read MSB flips 1->0, write MSB 0->1.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer RAM arbiter: VGA fetch has a hard slot, one writer fills idle slots.
// Optional FB_DOUBLE_BUFFER_EN adds a second bank swapped at the first visible pixel.
module vga_fb_arbiter #(
    parameter int FB_W  = 160,
    parameter int FB_H  = 120,
    parameter int SCALE = 2,
    parameter int H_OFF = 49,
    parameter int V_OFF = 33,
    parameter int AW    = 15,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vga_req,
    input  logic          vga_en,
    input  logic [9:0]    vga_col,
    input  logic [9:0]    vga_row,
    output logic [DW-1:0] pix_data,
    output logic          pix_valid,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
`ifdef FB_DOUBLE_BUFFER_EN
    output logic [AW:0]   mem_addr,
`else
    output logic [AW-1:0] mem_addr,
`endif
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef FB_DOUBLE_BUFFER_EN
    ,
    input  logic          swap_req,
    output logic          swap_done
`endif
);

`ifdef FB_DOUBLE_BUFFER_EN
    localparam int MAW = AW + 1;
`else
    localparam int MAW = AW;
`endif
    localparam int NPIX = FB_W * FB_H;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        WR   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           pend_q, pend_d;
    logic           req_en_q, req_en_d;
    logic [9:0]     req_col_q, req_col_d;
    logic [9:0]     req_row_q, req_row_d;
    logic           acc_q, acc_d;
    logic [DW-1:0]  pix_data_q, pix_data_d;
    logic           pix_valid_q, pix_valid_d;
    logic           wr_ready_q, wr_ready_d;
    logic [MAW-1:0] mem_addr_q, mem_addr_d;
    logic           mem_we_q, mem_we_d;
    logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
`ifdef FB_DOUBLE_BUFFER_EN
    logic           wr_bank_q, wr_bank_d;
    logic           swap_pend_q, swap_pend_d;
    logic           swap_done_q, swap_done_d;
    logic           first_pix;
`endif

    // A strobe in this cycle wins over the latched copy.
    logic           cur_en;
    logic [9:0]     cur_col, cur_row;
    logic [9:0]     dx, dy;
    logic [31:0]    rd_a;
    logic           rd_ok, wr_ok;

    assign cur_en  = vga_req ? vga_en  : req_en_q;
    assign cur_col = vga_req ? vga_col : req_col_q;
    assign cur_row = vga_req ? vga_row : req_row_q;
    assign dx      = cur_col - 10'(H_OFF);
    assign dy      = cur_row - 10'(V_OFF);
    assign rd_a    = 32'(dy >> SCALE) * 32'(FB_W) + 32'(dx >> SCALE);
    assign rd_ok   = rd_a < 32'(NPIX);
    assign wr_ok   = 32'(wr_addr) < 32'(NPIX);
`ifdef FB_DOUBLE_BUFFER_EN
    assign first_pix = (cur_col == 10'(H_OFF)) && (cur_row == 10'(V_OFF));
`endif

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        req_en_d    = req_en_q;
        req_col_d   = req_col_q;
        req_row_d   = req_row_q;
        acc_d       = acc_q;
        pix_data_d  = pix_data_q;
        pix_valid_d = 1'b0;
        wr_ready_d  = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
`ifdef FB_DOUBLE_BUFFER_EN
        wr_bank_d   = wr_bank_q;
        swap_pend_d = swap_pend_q | swap_req;
        swap_done_d = 1'b0;
`endif
        if (vga_req) begin
            req_en_d  = vga_en;
            req_col_d = vga_col;
            req_row_d = vga_row;
            if (state_q != IDLE) begin
                pend_d = 1'b1;
            end
        end
        unique case (state_q)
            IDLE: begin
                if (vga_req || pend_q) begin
                    state_d = RD;
                    pend_d  = 1'b0;
`ifdef FB_DOUBLE_BUFFER_EN
                    if (first_pix && swap_pend_d) begin
                        wr_bank_d   = ~wr_bank_q;
                        swap_pend_d = 1'b0;
                        swap_done_d = 1'b1;
                    end
`endif
                    acc_d = cur_en && rd_ok;
                    if (cur_en && rd_ok) begin
                        mem_addr_d = MAW'(rd_a[AW-1:0]);
`ifdef FB_DOUBLE_BUFFER_EN
                        mem_addr_d[AW] = ~wr_bank_d;
`endif
                    end
                end else if (wr_valid) begin
                    state_d     = WR;
                    wr_ready_d  = 1'b1;
                    mem_we_d    = wr_ok;
                    mem_addr_d  = MAW'(wr_addr);
`ifdef FB_DOUBLE_BUFFER_EN
                    mem_addr_d[AW] = wr_bank_q;
`endif
                    mem_wdata_d = wr_data;
                end
            end
            RD: state_d = CAP;
            CAP: begin
                state_d     = IDLE;
                pix_valid_d = 1'b1;
                pix_data_d  = acc_q ? mem_rdata : '0;
            end
            WR: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            req_en_q    <= 1'b0;
            req_col_q   <= '0;
            req_row_q   <= '0;
            acc_q       <= 1'b0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
`ifdef FB_DOUBLE_BUFFER_EN
            wr_bank_q   <= 1'b0;
            swap_pend_q <= 1'b0;
            swap_done_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            req_en_q    <= req_en_d;
            req_col_q   <= req_col_d;
            req_row_q   <= req_row_d;
            acc_q       <= acc_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
            wr_ready_q  <= wr_ready_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef FB_DOUBLE_BUFFER_EN
            wr_bank_q   <= wr_bank_d;
            swap_pend_q <= swap_pend_d;
            swap_done_q <= swap_done_d;
`endif
        end
    end

    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign wr_ready  = wr_ready_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
`ifdef FB_DOUBLE_BUFFER_EN
    assign swap_done = swap_done_q;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: RAM model, fetch scoreboard, writer tasks.
// Covers FB_DOUBLE_BUFFER_EN when that macro is defined.
module tb_vga_fb_arbiter;
    localparam int AW   = 15;
    localparam int DW   = 8;
    localparam int NPIX = 19200;
`ifdef FB_DOUBLE_BUFFER_EN
    localparam int MAW = AW + 1;
`else
    localparam int MAW = AW;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           vga_req = 1'b0;
    logic           vga_en = 1'b0;
    logic [9:0]     vga_col = '0;
    logic [9:0]     vga_row = '0;
    logic [DW-1:0]  pix_data;
    logic           pix_valid;
    logic           wr_valid = 1'b0;
    logic           wr_ready;
    logic [AW-1:0]  wr_addr = '0;
    logic [DW-1:0]  wr_data = '0;
    logic [MAW-1:0] mem_addr;
    logic           mem_we;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata;
`ifdef FB_DOUBLE_BUFFER_EN
    logic           swap_req = 1'b0;
    logic           swap_done;
`endif

    vga_fb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .vga_req(vga_req), .vga_en(vga_en),
        .vga_col(vga_col), .vga_row(vga_row),
        .pix_data(pix_data), .pix_valid(pix_valid),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef FB_DOUBLE_BUFFER_EN
        , .swap_req(swap_req), .swap_done(swap_done)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] ram [0:(1<<MAW)-1];
    logic [DW-1:0] shadow [0:(1<<MAW)-1];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic [DW-1:0] data;
        int            at;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    bit wb = 1'b0;
    logic [MAW-1:0] last_wr_addr;

    function automatic int addr_of(logic [9:0] col, logic [9:0] row);
        logic [9:0] dx;
        logic [9:0] dy;
        dx = col - 10'd49;
        dy = row - 10'd33;
        return int'(dy >> 2) * 160 + int'(dx >> 2);
    endfunction

    function automatic int rd_idx(int a);
`ifdef FB_DOUBLE_BUFFER_EN
        return (wb ? 0 : (1 << AW)) + a;
`else
        return a;
`endif
    endfunction

    function automatic int wr_idx(int a);
`ifdef FB_DOUBLE_BUFFER_EN
        return (wb ? (1 << AW) : 0) + a;
`else
        return a;
`endif
    endfunction

    function automatic logic [DW-1:0] exp_pix(bit en, logic [9:0] col, logic [9:0] row);
        int a;
        a = addr_of(col, row);
        if (!en || a >= NPIX) return '0;
        return shadow[rd_idx(a)];
    endfunction

    always @(negedge clk) begin
        if (rst_n && pix_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pix_unexpected: got %h at cyc %0d, none queued", pix_data, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (pix_data !== mon_e.data || cyc != mon_e.at) begin
                    errors++;
                    $display("FAIL pix: got %h at cyc %0d, want %h at cyc %0d",
                             pix_data, cyc, mon_e.data, mon_e.at);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_fetch(bit en, logic [9:0] col, logic [9:0] row, int lat);
        vga_req = 1'b1;
        vga_en  = en;
        vga_col = col;
        vga_row = row;
        sb.push_back('{exp_pix(en, col, row), cyc + lat});
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pixels outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic write_px(logic [AW-1:0] a, logic [DW-1:0] d);
        bit got;
        got = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (wr_ready) begin
                got = 1'b1;
                last_wr_addr = mem_addr;
            end
        end
        wr_valid = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wr_timeout: wr_ready=0 want 1 for addr %0d", a);
        end
        if (int'(a) < NPIX) shadow[wr_idx(int'(a))] = d;
        tick();
    endtask

    task automatic flip_if_db();
`ifdef FB_DOUBLE_BUFFER_EN
        swap_req = 1'b1;
        start_fetch(1'b0, 10'd49, 10'd33, 3);
        tick();
        swap_req = 1'b0;
        vga_req  = 1'b0;
        checks++;
        if (swap_done !== 1'b1) begin
            errors++;
            $display("FAIL flip_swap_done: got %b want 1", swap_done);
        end
        wb = ~wb;
        drain();
`endif
    endtask

    task automatic test_reset();
        bit bad;
        #2 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            bad = (pix_valid !== 1'b0) || (wr_ready !== 1'b0) || (mem_we !== 1'b0) ||
                  (pix_data !== '0) || (mem_addr !== '0) || (mem_wdata !== '0);
`ifdef FB_DOUBLE_BUFFER_EN
            bad = bad || (swap_done !== 1'b0);
`endif
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: pv=%b rdy=%b we=%b pd=%h ma=%h wd=%h want all 0",
                         cyc, pix_valid, wr_ready, mem_we, pix_data, mem_addr, mem_wdata);
            end
        end
    endtask

    task automatic test_fetch_basic();
        write_px(15'd0, 8'h5A);
        write_px(15'd161, 8'hA7);
        flip_if_db();
        start_fetch(1'b1, 10'd49, 10'd33, 3);
        tick();
        vga_req = 1'b0;
        checks++;
        if (mem_addr !== MAW'(rd_idx(0)) || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL fetch0_addr: addr=%0d we=%b want addr=%0d we=0",
                     mem_addr, mem_we, rd_idx(0));
        end
        drain();
    endtask

    task automatic test_fetch_offset();
        start_fetch(1'b1, 10'd53, 10'd37, 3);
        tick();
        vga_req = 1'b0;
        checks++;
        if (mem_addr !== MAW'(rd_idx(161))) begin
            errors++;
            $display("FAIL fetch161_addr: got %0d want %0d", mem_addr, rd_idx(161));
        end
        drain();
        start_fetch(1'b0, 10'd49, 10'd33, 3);
        tick();
        vga_req = 1'b0;
        checks++;
        if (mem_addr !== MAW'(rd_idx(161)) || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL fetch_en0_hold: addr=%0d we=%b want addr=%0d we=0",
                     mem_addr, mem_we, rd_idx(161));
        end
        drain();
        start_fetch(1'b1, 10'd49, 10'd513, 3);
        tick();
        vga_req = 1'b0;
        checks++;
        if (mem_addr !== MAW'(rd_idx(161))) begin
            errors++;
            $display("FAIL fetch_oob_hold: got %0d want %0d", mem_addr, rd_idx(161));
        end
        drain();
    endtask

    task automatic test_write_then_fetch();
        wr_valid = 1'b1;
        wr_addr  = 15'd200;
        wr_data  = 8'h3C;
        tick();
        checks++;
        if (wr_ready !== 1'b1 || mem_we !== 1'b1 ||
            mem_addr !== MAW'(wr_idx(200)) || mem_wdata !== 8'h3C) begin
            errors++;
            $display("FAIL wr200: rdy=%b we=%b addr=%0d wd=%h want 1 1 %0d 3c",
                     wr_ready, mem_we, mem_addr, mem_wdata, wr_idx(200));
        end
        wr_valid = 1'b0;
        shadow[wr_idx(200)] = 8'h3C;
        start_fetch(1'b1, 10'd49, 10'd33, 4);
        tick();
        vga_req = 1'b0;
        drain();
        checks++;
        if (ram[wr_idx(200)] !== 8'h3C) begin
            errors++;
            $display("FAIL ram200: got %h want 3c", ram[wr_idx(200)]);
        end
    endtask

    task automatic test_drop_write();
        bit got;
        bit seen_we;
        got = 1'b0;
        seen_we = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 15'd19200;
        wr_data  = 8'hFF;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (mem_we) seen_we = 1'b1;
            if (wr_ready) got = 1'b1;
        end
        wr_valid = 1'b0;
        tick();
        if (mem_we) seen_we = 1'b1;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL drop_ready: wr_ready=0 want 1");
        end
        checks++;
        if (seen_we) begin
            errors++;
            $display("FAIL drop_we: mem_we=1 want 0");
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [3];
        logic [DW-1:0] vals [3];
        int at [3];
        bit got;
        addrs = '{15'd300, 15'd301, 15'd302};
        vals  = '{8'h81, 8'h82, 8'h83};
        wr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wr_addr = addrs[k];
            wr_data = vals[k];
            got = 1'b0;
            at[k] = -1;
            for (int i = 0; i < 10 && !got; i++) begin
                tick();
                if (wr_ready) begin
                    got = 1'b1;
                    at[k] = cyc;
                end
            end
            shadow[wr_idx(int'(addrs[k]))] = vals[k];
        end
        wr_valid = 1'b0;
        tick();
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (at[k] - at[k-1] != 2) begin
                errors++;
                $display("FAIL b2b_gap%0d: got %0d want 2", k, at[k] - at[k-1]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ram[wr_idx(int'(addrs[k]))] !== vals[k]) begin
                errors++;
                $display("FAIL b2b_ram%0d: got %h want %h",
                         k, ram[wr_idx(int'(addrs[k]))], vals[k]);
            end
        end
    endtask

    task automatic test_pend_overwrite();
        start_fetch(1'b0, 10'd53, 10'd37, 3);
        tick();
        vga_en  = 1'b1;
        vga_col = 10'd53;
        vga_row = 10'd37;
        tick();
        start_fetch(1'b1, 10'd49, 10'd33, 4);
        tick();
        vga_req = 1'b0;
        drain();
    endtask

    task automatic test_mid_reset();
        start_fetch(1'b1, 10'd49, 10'd33, 3);
        tick();
        vga_req = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_addr !== '0 || pix_data !== '0 || pix_valid !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: addr=%0d pd=%h pv=%b we=%b want all 0",
                     mem_addr, pix_data, pix_valid, mem_we);
        end
        sb.delete();
        wb = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        start_fetch(1'b0, 10'd53, 10'd37, 3);
        tick();
        vga_req = 1'b0;
        drain();
    endtask

    task automatic test_swap();
`ifdef FB_DOUBLE_BUFFER_EN
        write_px(15'd0, 8'h44);
        checks++;
        if (last_wr_addr[AW] !== 1'b0) begin
            errors++;
            $display("FAIL swap_wr_msb_pre: got %b want 0", last_wr_addr[AW]);
        end
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        start_fetch(1'b0, 10'd50, 10'd40, 3);
        tick();
        vga_req = 1'b0;
        checks++;
        if (swap_done !== 1'b0) begin
            errors++;
            $display("FAIL swap_early: swap_done=%b want 0", swap_done);
        end
        drain();
        wb = 1'b1;
        start_fetch(1'b1, 10'd49, 10'd33, 3);
        tick();
        vga_req = 1'b0;
        checks++;
        if (swap_done !== 1'b1 || mem_addr !== '0) begin
            errors++;
            $display("FAIL swap_apply: done=%b addr=%h want 1 0", swap_done, mem_addr);
        end
        drain();
        write_px(15'd0, 8'h55);
        checks++;
        if (last_wr_addr[AW] !== 1'b1) begin
            errors++;
            $display("FAIL swap_wr_msb_post: got %b want 1", last_wr_addr[AW]);
        end
        start_fetch(1'b1, 10'd49, 10'd33, 3);
        tick();
        vga_req = 1'b0;
        drain();
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch_basic();
        test_fetch_offset();
        test_write_then_fetch();
        test_drop_write();
        test_back_to_back();
        test_pend_overwrite();
        test_mid_reset();
        test_swap();
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
